// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, fixed XLEN+1 cycle latency, with pipeline stall and flush support.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       operand1,
  input  logic [XLEN-1:0]       operand2,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  flush,
  output logic                  ready,
  output logic                  stall,
  output logic                  valid_out,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         counter;
  logic [2:0]            op_f3;
  logic [REG_ADDR_W-1:0] op_rd;
  logic [XLEN-1:0]       hi, lo, mcand;
  logic                  neg_res, neg_rem, special;
  logic [XLEN-1:0]       special_val;

  logic                  accept, last;
  logic                  sign1, sign2, neg1, neg2;
  logic [XLEN-1:0]       mag1, mag2;
  logic                  is_special;
  logic [XLEN-1:0]       special_in;

  logic [XLEN:0]         mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]       hi_next, lo_next;
  logic [2*XLEN-1:0]     prod, prod_s;
  logic [XLEN-1:0]       mul_res, div_res, final_res;

  assign accept = (state == IDLE) && valid_in && !flush;
  assign last   = (state == CALC) && (counter == LAST_CNT);

  // Operand conditioning at accept: signedness, magnitudes and the div special cases.
  always_comb begin
    sign1      = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    sign2      = sign1 && (funct3 != 3'b010);
    neg1       = sign1 && operand1[XLEN-1];
    neg2       = sign2 && operand2[XLEN-1];
    mag1       = neg1 ? -operand1 : operand1;
    mag2       = neg2 ? -operand2 : operand2;
    is_special = 1'b0;
    special_in = '0;
    if (funct3[2]) begin
      if (operand2 == '0) begin
        is_special = 1'b1;
        special_in = funct3[1] ? operand1 : '1;
      end else if (!funct3[0] && (operand1 == MIN_INT) && (operand2 == '1)) begin
        is_special = 1'b1;
        special_in = funct3[1] ? '0 : MIN_INT;
      end
    end
  end

  // One iteration: hi/lo form the product (multiply) or remainder/quotient (divide).
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    hi_next   = hi;
    lo_next   = lo;
    if (op_f3[2]) begin
      hi_next = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod      = {hi_next, lo_next};
    prod_s    = neg_res ? -prod : prod;
    mul_res   = (op_f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    if (op_f3[1]) div_res = neg_rem ? -hi_next : hi_next;
    else          div_res = neg_res ? -lo_next : lo_next;
    final_res = special ? special_val : (op_f3[2] ? div_res : mul_res);
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    stall      = 1'b0;
    valid_out  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        stall = valid_in && !flush;
        if (valid_in && !flush) state_next = CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE: begin
        valid_out  = !flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      op_f3       <= '0;
      op_rd       <= '0;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      result      <= '0;
      rd_out      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_f3       <= funct3;
        op_rd       <= rd_in;
        counter     <= '0;
        hi          <= '0;
        lo          <= funct3[2] ? mag1 : mag2;
        mcand       <= funct3[2] ? mag2 : mag1;
        neg_res     <= neg1 ^ neg2;
        neg_rem     <= neg1;
        special     <= is_special;
        special_val <= special_in;
      end else if (state == CALC) begin
        hi      <= hi_next;
        lo      <= lo_next;
        counter <= counter + 1'b1;
        if (last && !flush) begin
          result <= final_res;
          rd_out <= op_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written flush / reset corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        ready, stall, valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .funct3(funct3),
    .operand1(operand1), .operand2(operand2), .rd_in(rd_in), .flush(flush),
    .ready(ready), .stall(stall), .valid_out(valid_out),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, q;
    sa = a;
    sb = b;
    p  = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, wait (bounded) for valid_out, and check latency, stall span and pulse width.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noise, output logic [31:0] res);
    int edges;
    int stall_cnt;
    @(negedge clk);
    valid_in = 1'b1; funct3 = f3; operand1 = a; operand2 = b; rd_in = rd;
    #1 chk("stall_on_request", {31'b0, stall}, 32'd1);
    @(posedge clk);
    edges = 1;
    stall_cnt = 0;
    #1;
    valid_in = noise;
    if (noise) begin
      funct3 = 3'($urandom); operand1 = $urandom; operand2 = $urandom; rd_in = 5'($urandom);
    end
    while (!valid_out && edges < 100) begin
      if (stall) stall_cnt++;
      @(posedge clk);
      edges++;
      #1;
    end
    valid_in = 1'b0;
    res = result;
    chk("latency_edges", edges, 33);
    chk("stall_cycles", stall_cnt, 32);
    chk("stall_in_done", {31'b0, stall}, 32'd0);
    chk("rd_out", {27'b0, rd_out}, {27'b0, rd});
    @(posedge clk);
    #1;
    chk("valid_pulse_end", {31'b0, valid_out}, 32'd0);
    chk("ready_after_done", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, a, b, exp;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          saw;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{3'b111, 32'd5,          32'd0,         32'd5};

    // Reset state
    #12;
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_valid", {31'b0, valid_out}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0, res);
      chk($sformatf("vec%0d_f3_%0d", i, vecs[i].f3), res, vecs[i].exp);
    end

    for (int n = 0; n < 48; n++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = 32'h8000_0000;
        default: ;
      endcase
      rd  = 5'($urandom);
      exp = model(f3, a, b);
      do_op(f3, a, b, rd, n[0], res);
      chk($sformatf("rand%0d_f3_%0d", n, f3), res, exp);
    end

    // Flush has priority over a request in IDLE
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b1; funct3 = 3'b000; operand1 = 32'd9; operand2 = 32'd9;
    #1 chk("flush_req_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1 chk("flush_req_ready", {31'b0, ready}, 32'd1);
    valid_in = 1'b0; flush = 1'b0;

    // Flush in the middle of CALC
    @(negedge clk);
    valid_in = 1'b1; funct3 = 3'b000; operand1 = 32'd5; operand2 = 32'd6; rd_in = 5'd9;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready}, 32'd1);
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) saw = 1'b1;
    end
    chk("flush_no_valid", {31'b0, saw}, 32'd0);
    do_op(3'b000, 32'd3, 32'd4, 5'd12, 1'b0, res);
    chk("after_flush_mul", res, 32'd12);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    valid_in = 1'b1; funct3 = 3'b100; operand1 = 32'd77; operand2 = 32'd5; rd_in = 5'd3;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'b0, ready}, 32'd1);
    chk("async_rst_stall", {31'b0, stall}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_rd", {27'b0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b101, 32'd9, 32'd3, 5'd7, 1'b0, res);
    chk("after_rst_divu", res, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
